// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline stage register with skid buffer, flush and NOP injection
// Optional statistics counters are enabled with the macro PIPE_STAGE_STATS_EN.
module pipe_stage_reg #(
  parameter int                DATA_W   = 64,
  parameter int                CTRL_W   = 8,
  parameter logic [DATA_W-1:0] NOP_DATA = DATA_W'(64'h13),
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_data, main_data_nxt;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt;
  logic [DATA_W-1:0] skid_data, skid_data_nxt;
  logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nxt;
  logic              in_fire, out_fire;

  // Handshake flags are decoded straight from the state register, so in_ready
  // never depends combinationally on out_ready.
  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_TWO);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl & {CTRL_W{out_valid}};

  // State, main and skid registers; everything returns to the bubble image on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      main_data <= NOP_DATA;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state     <= state_nxt;
      main_data <= main_data_nxt;
      main_ctrl <= main_ctrl_nxt;
      skid_data <= skid_data_nxt;
      skid_ctrl <= skid_ctrl_nxt;
    end
  end

  // Next-state and slot contents; flush overrides every other transition.
  always_comb begin
    state_nxt     = state;
    main_data_nxt = main_data;
    main_ctrl_nxt = main_ctrl;
    skid_data_nxt = skid_data;
    skid_ctrl_nxt = skid_ctrl;
    if (flush) begin
      state_nxt     = ST_EMPTY;
      main_data_nxt = NOP_DATA;
      main_ctrl_nxt = '0;
      skid_data_nxt = '0;
      skid_ctrl_nxt = '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_data_nxt = in_data;
            main_ctrl_nxt = in_ctrl;
            state_nxt     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_data_nxt = in_data;
            main_ctrl_nxt = in_ctrl;
          end else if (in_fire) begin
            skid_data_nxt = in_data;
            skid_ctrl_nxt = in_ctrl;
            state_nxt     = ST_TWO;
          end else if (out_fire) begin
            main_data_nxt = NOP_DATA;
            main_ctrl_nxt = '0;
            state_nxt     = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            main_data_nxt = skid_data;
            main_ctrl_nxt = skid_ctrl;
            skid_data_nxt = '0;
            skid_ctrl_nxt = '0;
            state_nxt     = ST_ONE;
          end
        end
        default: begin
          state_nxt     = ST_EMPTY;
          main_data_nxt = NOP_DATA;
          main_ctrl_nxt = '0;
          skid_data_nxt = '0;
          skid_ctrl_nxt = '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_q, bubble_q;

  // Saturating stall/bubble counters; flush deliberately leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + 1'b1;
      if (!out_valid && (bubble_q != {CNT_W{1'b1}}))
        bubble_q <= bubble_q + 1'b1;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
